// File: rtl/cnv_post_quant.sv
// Streaming post-quant stage: bias add, ReLU, round-half-up requantise, saturate (4 stages).
// Define CNV_POST_LEAKY_EN to add I_leaky_shift and turn ReLU into a leaky ReLU.
module cnv_post_quant #(
    parameter int unsigned LANES      = 16,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned BIAS_W     = 8,
    parameter int unsigned BIAS_DEPTH = 64,
    parameter int unsigned SHW        = 6
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_cfg_load,
    input  logic signed [SHW:0]           I_bias_shift,
    input  logic signed [SHW:0]           I_out_shift,
    input  logic                          I_relu_en,
    input  logic [15:0]                   I_groups,
    input  logic [31:0]                   I_total,
`ifdef CNV_POST_LEAKY_EN
    input  logic [SHW-1:0]                I_leaky_shift,
`endif
    input  logic                          I_bias_we,
    input  logic [$clog2(BIAS_DEPTH)-1:0] I_bias_addr,
    input  logic [LANES*BIAS_W-1:0]       I_bias_data,
    input  logic [LANES*ACC_W-1:0]        I_acc_data,
    input  logic                          I_acc_valid,
    output logic                          O_acc_ready,
    output logic [LANES*DWIDTH-1:0]       O_data,
    output logic                          O_valid,
    input  logic                          I_ready,
    output logic                          O_last,
    output logic                          O_busy,
    output logic [31:0]                   O_sat_cnt
);

    localparam int unsigned AW  = $clog2(BIAS_DEPTH);
    localparam int unsigned SHP = SHW + 1;
    localparam int unsigned SW  = ACC_W + 2;
    localparam int unsigned SW1 = SW + 1;
    localparam int unsigned WW  = SW + (1 << SHW);
    localparam logic [SHW:0]          MAX_SH  = SHP'(ACC_W);
    localparam logic signed [WW-1:0]  MAX_OUT = WW'((1 << (DWIDTH - 1)) - 1);
    localparam logic signed [WW-1:0]  MIN_OUT = WW'(-(1 << (DWIDTH - 1)));

    function automatic logic [SHW:0] shift_mag(input logic signed [SHW:0] k);
        logic [SHW:0] m;
        m = k[SHW] ? SHP'(-k) : SHP'(k);
        return (m > MAX_SH) ? MAX_SH : m;
    endfunction

    function automatic logic signed [SW-1:0] add_bias(input logic signed [ACC_W-1:0] acc,
                                                      input logic [BIAS_W-1:0] braw,
                                                      input logic left, input logic [SHW:0] mag);
        logic signed [SW-1:0] b;
        b = SW'($signed(braw));
        b = left ? (b <<< mag) : (b >>> mag);
        return SW'(acc) + b;
    endfunction

    // One extra bit keeps the rounding add from wrapping near the positive limit.
    function automatic logic signed [WW-1:0] requant(input logic signed [SW-1:0] v,
                                                     input logic right, input logic [SHW:0] mag);
        logic signed [SW:0] t;
        logic signed [SW:0] rnd;
        if (right) begin
            rnd = SW1'(1) << (mag - SHP'(1));
            t   = SW1'(v) + rnd;
            t   = t >>> mag;
            return WW'(t);
        end
        return WW'(v) <<< mag;
    endfunction

    function automatic logic [DWIDTH:0] sat_lane(input logic signed [WW-1:0] x);
        if (x > MAX_OUT) return {1'b1, MAX_OUT[DWIDTH-1:0]};
        if (x < MIN_OUT) return {1'b1, MIN_OUT[DWIDTH-1:0]};
        return {1'b0, x[DWIDTH-1:0]};
    endfunction

    logic signed [SHW:0] bias_shift_q, bias_shift_d, out_shift_q, out_shift_d;
    logic                relu_q, relu_d;
    logic [15:0]         groups_q, groups_d, grp_q, grp_d;
    logic [31:0]         total_q, total_d, beat_q, beat_d, sat_q, sat_d;
    logic                busy_q, busy_d;
`ifdef CNV_POST_LEAKY_EN
    logic [SHW-1:0]      leaky_q, leaky_d;
`endif

    logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    logic o_valid_q, o_valid_d, o_last_q, o_last_d;
    logic signed [ACC_W-1:0] s1_acc_q [LANES];
    logic signed [ACC_W-1:0] s1_acc_d [LANES];
    logic signed [SW-1:0]    s2_sum_q [LANES];
    logic signed [SW-1:0]    s2_sum_d [LANES];
    logic signed [SW-1:0]    relu_v   [LANES];
    logic signed [WW-1:0]    s3_val_q [LANES];
    logic signed [WW-1:0]    s3_val_d [LANES];
    logic [DWIDTH:0]         sat_res  [LANES];
    logic [LANES*DWIDTH-1:0] o_data_q, o_data_d;
    logic [LANES*BIAS_W-1:0] bias_mem [BIAS_DEPTH];
    logic [LANES*BIAS_W-1:0] bias_rd_q;

    logic        en, accept, cfg_ok, beat_last, bs_left, os_right;
    logic [SHW:0] bs_mag, os_mag;
    logic [16:0] grp_inc;
    logic [31:0] nclip, sat_base;
    logic [32:0] sat_sum;

    assign bs_mag   = shift_mag(bias_shift_q);
    assign os_mag   = shift_mag(out_shift_q);
    assign bs_left  = !bias_shift_q[SHW];
    assign os_right = !out_shift_q[SHW] && (out_shift_q != '0);

    always_comb begin
        en        = !o_valid_q || I_ready;
        accept    = I_acc_valid && en;
        cfg_ok    = I_cfg_load && !busy_q;
        beat_last = (total_q != '0) && (beat_q == total_q - 32'd1);
        grp_inc   = {1'b0, grp_q} + 17'd1;

        bias_shift_d = cfg_ok ? I_bias_shift : bias_shift_q;
        out_shift_d  = cfg_ok ? I_out_shift  : out_shift_q;
        relu_d       = cfg_ok ? I_relu_en    : relu_q;
        groups_d     = cfg_ok ? I_groups     : groups_q;
        total_d      = cfg_ok ? I_total      : total_q;
`ifdef CNV_POST_LEAKY_EN
        leaky_d      = cfg_ok ? I_leaky_shift : leaky_q;
`endif

        // Counters restart at a frame boundary so every frame begins at channel group 0.
        grp_d  = grp_q;
        beat_d = beat_q;
        if (accept) begin
            beat_d = beat_last ? '0 : beat_q + 32'd1;
            grp_d  = (beat_last || grp_inc >= {1'b0, groups_q}) ? '0 : grp_inc[15:0];
        end else if (cfg_ok) begin
            grp_d  = '0;
            beat_d = '0;
        end

        busy_d = busy_q;
        if (o_valid_q && o_last_q && I_ready) busy_d = 1'b0;
        if (accept) busy_d = 1'b1;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;  s1_last_d = s1_last_q;  s1_acc_d = s1_acc_q;
        s2_valid_d = s2_valid_q;  s2_last_d = s2_last_q;  s2_sum_d = s2_sum_q;
        s3_valid_d = s3_valid_q;  s3_last_d = s3_last_q;  s3_val_d = s3_val_q;
        o_valid_d  = o_valid_q;   o_last_d  = o_last_q;   o_data_d = o_data_q;
        nclip      = '0;
        for (int i = 0; i < LANES; i++) begin
            relu_v[i] = s2_sum_q[i];
`ifdef CNV_POST_LEAKY_EN
            if (relu_q && s2_sum_q[i][SW-1]) relu_v[i] = s2_sum_q[i] >>> leaky_q;
`else
            if (relu_q && s2_sum_q[i][SW-1]) relu_v[i] = '0;
`endif
            sat_res[i] = sat_lane(s3_val_q[i]);
            nclip      = nclip + 32'(sat_res[i][DWIDTH]);
        end
        if (en) begin
            s1_valid_d = I_acc_valid;
            s1_last_d  = I_acc_valid && beat_last;
            s2_valid_d = s1_valid_q;  s2_last_d = s1_last_q;
            s3_valid_d = s2_valid_q;  s3_last_d = s2_last_q;
            o_valid_d  = s3_valid_q;  o_last_d  = s3_last_q;
            for (int i = 0; i < LANES; i++) begin
                s1_acc_d[i] = $signed(I_acc_data[i*ACC_W +: ACC_W]);
                s2_sum_d[i] = add_bias(s1_acc_q[i], bias_rd_q[i*BIAS_W +: BIAS_W],
                                       bs_left, bs_mag);
                s3_val_d[i] = requant(relu_v[i], os_right, os_mag);
                o_data_d[i*DWIDTH +: DWIDTH] = sat_res[i][DWIDTH-1:0];
            end
        end
        sat_base = (accept && beat_q == '0) ? '0 : sat_q;
        sat_sum  = {1'b0, sat_base} + ((en && s3_valid_q) ? {1'b0, nclip} : 33'd0);
        sat_d    = sat_sum[32] ? '1 : sat_sum[31:0];
    end

    // Bias RAM: read-before-write, contents not reset.
    always_ff @(posedge I_clk) begin
        if (I_bias_we) bias_mem[I_bias_addr] <= I_bias_data;
        if (en) bias_rd_q <= bias_mem[grp_q[AW-1:0]];
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            bias_shift_q <= '0;  out_shift_q <= '0;  relu_q <= 1'b0;
            groups_q     <= 16'd1;  total_q <= '0;
`ifdef CNV_POST_LEAKY_EN
            leaky_q      <= '0;
`endif
            grp_q <= '0;  beat_q <= '0;  busy_q <= 1'b0;  sat_q <= '0;
            s1_valid_q <= 1'b0;  s1_last_q <= 1'b0;  s1_acc_q <= '{default: '0};
            s2_valid_q <= 1'b0;  s2_last_q <= 1'b0;  s2_sum_q <= '{default: '0};
            s3_valid_q <= 1'b0;  s3_last_q <= 1'b0;  s3_val_q <= '{default: '0};
            o_valid_q  <= 1'b0;  o_last_q  <= 1'b0;  o_data_q <= '0;
        end else begin
            bias_shift_q <= bias_shift_d;  out_shift_q <= out_shift_d;  relu_q <= relu_d;
            groups_q     <= groups_d;      total_q     <= total_d;
`ifdef CNV_POST_LEAKY_EN
            leaky_q      <= leaky_d;
`endif
            grp_q <= grp_d;  beat_q <= beat_d;  busy_q <= busy_d;  sat_q <= sat_d;
            s1_valid_q <= s1_valid_d;  s1_last_q <= s1_last_d;  s1_acc_q <= s1_acc_d;
            s2_valid_q <= s2_valid_d;  s2_last_q <= s2_last_d;  s2_sum_q <= s2_sum_d;
            s3_valid_q <= s3_valid_d;  s3_last_q <= s3_last_d;  s3_val_q <= s3_val_d;
            o_valid_q  <= o_valid_d;   o_last_q  <= o_last_d;   o_data_q <= o_data_d;
        end
    end

    assign O_acc_ready = en;
    assign O_data      = o_data_q;
    assign O_valid     = o_valid_q;
    assign O_last      = o_last_q;
    assign O_busy      = busy_q;
    assign O_sat_cnt   = sat_q;

endmodule

// File: tb/tb_cnv_post_quant.sv
// Directed self-checking bench for cnv_post_quant with hand-computed expectations.
module tb_cnv_post_quant;

    localparam int LANES = 16, ACC_W = 24, DWIDTH = 8, BIAS_W = 8, BIAS_DEPTH = 64, SHW = 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    cfg_load;
    logic signed [SHW:0]     bias_shift, out_shift;
    logic                    relu_en;
    logic [15:0]             groups;
    logic [31:0]             total;
`ifdef CNV_POST_LEAKY_EN
    logic [SHW-1:0]          leaky_shift;
`endif
    logic                    bias_we;
    logic [5:0]              bias_addr;
    logic [LANES*BIAS_W-1:0] bias_data;
    logic [LANES*ACC_W-1:0]  acc_data;
    logic                    acc_valid;
    logic                    acc_ready;
    logic [LANES*DWIDTH-1:0] o_data;
    logic                    o_valid, ready, o_last, o_busy;
    logic [31:0]             sat_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    cnv_post_quant #(
        .LANES(LANES), .ACC_W(ACC_W), .DWIDTH(DWIDTH), .BIAS_W(BIAS_W),
        .BIAS_DEPTH(BIAS_DEPTH), .SHW(SHW)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_cfg_load(cfg_load),
        .I_bias_shift(bias_shift), .I_out_shift(out_shift), .I_relu_en(relu_en),
        .I_groups(groups), .I_total(total),
`ifdef CNV_POST_LEAKY_EN
        .I_leaky_shift(leaky_shift),
`endif
        .I_bias_we(bias_we), .I_bias_addr(bias_addr), .I_bias_data(bias_data),
        .I_acc_data(acc_data), .I_acc_valid(acc_valid), .O_acc_ready(acc_ready),
        .O_data(o_data), .O_valid(o_valid), .I_ready(ready), .O_last(o_last),
        .O_busy(o_busy), .O_sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint lane(input logic [LANES*DWIDTH-1:0] d, input int i);
        return longint'($signed(d[i*DWIDTH +: DWIDTH]));
    endfunction

    task automatic write_bias(input int addr, input int val);
        @(negedge clk);
        bias_we = 1'b1;  bias_addr = 6'(addr);  bias_data = {LANES{BIAS_W'(val)}};
        @(negedge clk);
        bias_we = 1'b0;
    endtask

    task automatic load_cfg(input int bs, input int os, input bit relu, input int grp,
                            input int tot);
        @(negedge clk);
        bias_shift = 7'(bs);  out_shift = 7'(os);  relu_en = relu;
        groups = 16'(grp);  total = 32'(tot);  cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic run_beat(input int acc, output logic [LANES*DWIDTH-1:0] data,
                            output int lat, output logic last);
        @(negedge clk);
        acc_valid = 1'b1;  acc_data = {LANES{ACC_W'(acc)}};
        @(negedge clk);
        acc_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = o_data;
        last = o_last;
    endtask

    task automatic beat_test(input string tag, input int acc, input int exp, input int exp_sat);
        logic [LANES*DWIDTH-1:0] d;
        int   lat;
        logic last;
        run_beat(acc, d, lat, last);
        check({tag, "_lane0"}, lane(d, 0), exp);
        check({tag, "_lane15"}, lane(d, 15), exp);
        check({tag, "_sat"}, sat_cnt, exp_sat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*DWIDTH-1:0] d;
        logic [LANES*DWIDTH-1:0] held_data;
        int   lat, got, k, j;
        logic last, held, seen;
        int   exp_grp [7] = '{1, 2, 3, 1, 2, 3, 1};

        rst_n = 1'b0;  cfg_load = 1'b0;  bias_shift = '0;  out_shift = '0;  relu_en = 1'b0;
        groups = 16'd1;  total = '0;  bias_we = 1'b0;  bias_addr = '0;  bias_data = '0;
        acc_data = '0;  acc_valid = 1'b0;  ready = 1'b1;
`ifdef CNV_POST_LEAKY_EN
        leaky_shift = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_sat", sat_cnt, 0);
        check("rst_data_zero", longint'(o_data == '0), 1);
        rst_n = 1'b1;

        // (100 + (3<<2) + 4) >> 3 = 14
        write_bias(0, 3);
        load_cfg(2, 3, 1'b0, 1, 1);
        run_beat(100, d, lat, last);
        check("t1_latency", lat, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_lane%0d", i), lane(d, i), 14);
        check("t1_last", last, 1);
        check("t1_busy_in_flight", o_busy, 1);
        @(negedge clk);
        check("t1_busy_after", o_busy, 0);

        load_cfg(2, 3, 1'b1, 1, 1);
        beat_test("relu_neg", -5000, 0, 0);
        load_cfg(2, 3, 1'b0, 1, 1);
        beat_test("neg_sat", -5000, -128, LANES);

        write_bias(0, 0);
        load_cfg(0, 1, 1'b0, 1, 1);
        beat_test("rnd_pos", 5, 3, 0);
        beat_test("rnd_neg", -5, -2, 0);
        load_cfg(0, -4, 1'b0, 1, 1);
        beat_test("shl4", 1, 16, 0);
        load_cfg(0, 0, 1'b0, 1, 1);
        beat_test("max_ok", 127, 127, 0);
        beat_test("max_clip", 128, 127, LANES);
        beat_test("min_ok", -128, -128, 0);
        beat_test("min_clip", -129, -128, LANES);

        // Channel groups, frame-last tagging and an ignored mid-frame config load
        write_bias(0, 1);
        write_bias(1, 2);
        write_bias(2, 3);
        load_cfg(0, 0, 1'b0, 3, 7);
        got = 0;
        fork
            begin
                for (int b = 0; b < 7; b++) begin
                    @(negedge clk);
                    acc_valid = 1'b1;  acc_data = '0;
                    if (b == 2) begin
                        bias_shift = 7'(3);  out_shift = 7'(2);  groups = 16'd1;
                        total = 32'd2;  cfg_load = 1'b1;
                    end else begin
                        cfg_load = 1'b0;
                    end
                end
                @(negedge clk);
                acc_valid = 1'b0;  cfg_load = 1'b0;
            end
            begin
                for (int c = 0; c < 40 && got < 7; c++) begin
                    @(negedge clk);
                    #1;
                    if (o_valid) begin
                        check($sformatf("grp_beat%0d", got), lane(o_data, 0), exp_grp[got]);
                        check($sformatf("grp_last%0d", got), o_last, (got == 6) ? 1 : 0);
                        if (got == 0) check("grp_busy", o_busy, 1);
                        got++;
                    end
                end
            end
        join
        check("grp_count", got, 7);
        @(negedge clk);
        check("grp_busy_drop", o_busy, 0);

        // 64 beats under random backpressure
        write_bias(0, 0);
        load_cfg(0, 0, 1'b0, 1, 64);
        k = 0;  j = 0;  held = 1'b0;  held_data = '0;
        for (int c = 0; c < 2000 && j < 64; c++) begin
            @(negedge clk);
            ready     = 1'($urandom_range(0, 1));
            acc_valid = (k < 64);
            for (int i = 0; i < LANES; i++) acc_data[i*ACC_W +: ACC_W] = ACC_W'(k + i);
            #1;
            if (held) begin
                check("bp_hold_valid", o_valid, 1);
                check("bp_hold_data", longint'(o_data == held_data), 1);
            end
            check("bp_acc_ready", acc_ready, (!o_valid || ready) ? 1 : 0);
            held      = o_valid && !ready;
            held_data = o_data;
            if (o_valid && ready) begin
                check($sformatf("bp_lane0_%0d", j), lane(o_data, 0), j);
                check($sformatf("bp_lane15_%0d", j), lane(o_data, 15), j + 15);
                check($sformatf("bp_last_%0d", j), o_last, (j == 63) ? 1 : 0);
                j++;
            end
            if (acc_valid && acc_ready) k++;
        end
        acc_valid = 1'b0;
        ready     = 1'b1;
        check("bp_out_count", j, 64);
        check("bp_in_count", k, 64);
        @(negedge clk);
        check("bp_busy_drop", o_busy, 0);

        // Reset two cycles after acceptance flushes the pipeline
        load_cfg(0, 0, 1'b0, 1, 1);
        @(negedge clk);
        acc_valid = 1'b1;  acc_data = {LANES{ACC_W'(5000)}};
        @(negedge clk);
        acc_valid = 1'b0;
        @(negedge clk);
        check("rr_busy_before", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("rr_valid_now", o_valid, 0);
        check("rr_busy_now", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        check("rr_no_output", seen, 0);
        check("rr_sat", sat_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnv_post_quant.md
Name: cnv_post_quant

Overview:
- Parametrised streaming successor to the convolution post-processing stage.
- Takes LANES wide signed accumulator beats from the PE array and adds a per-channel-group bias from an internal bias RAM.
- Applies optional ReLU, round-half-up requantisation shift and saturation, and emits DWIDTH-bit activations.
- Full valid/ready backpressure on input and output, plus a frame-last marker for the DDR write engine.

Parameters:
LANES, 16, output channels per beat
ACC_W, 24, signed accumulator width per lane
DWIDTH, 8, signed output width per lane
BIAS_W, 8, signed bias width per lane
BIAS_DEPTH, 64, bias RAM entries (channel groups); power of two
SHW, 6, shift magnitude width; shift ports are SHW+1 bits signed

Ports:
I_clk  in  1  clock
I_rst_n  in  1  asynchronous active-low reset
I_cfg_load  in  1  pulse; latches configuration ports when idle
I_bias_shift  in  SHW+1  signed; >0 shifts bias left, <0 arithmetic right
I_out_shift  in  SHW+1  signed; >0 round-and-shift right, <=0 shift left
I_relu_en  in  1  ReLU enable
I_groups  in  16  channel groups per pixel; bias index wraps here
I_total  in  32  beats per frame
I_bias_we  in  1  bias RAM write strobe
I_bias_addr  in  log2(BIAS_DEPTH)  bias write address
I_bias_data  in  LANES*BIAS_W  bias vector
I_acc_data  in  LANES*ACC_W  accumulator beat
I_acc_valid  in  1  beat valid
O_acc_ready  out  1  beat accepted when valid&&ready
O_data  out  LANES*DWIDTH  activation beat
O_valid  out  1  output valid
I_ready  in  1  downstream ready
O_last  out  1  high with final beat of frame
O_busy  out  1  frame in progress
O_sat_cnt  out  32  saturated lanes this frame

Behaviour:
- Reset values:
  - All outputs 0; group and beat counters 0.
  - Config defaults: shifts 0, relu 0, groups 1, total 0.
  - Bias RAM contents undefined.
- Config:
  - I_cfg_load is honoured only when O_busy=0; it is ignored while busy.
  - O_busy sets on the first accepted beat and clears on the cycle O_last is accepted downstream.
  - O_sat_cnt clears on the first accepted beat of a frame.
- Pipeline enable and handshake:
  - en = !O_valid || I_ready; O_acc_ready = en.
  - When en=0, all four stages hold.
  - Throughput is 1 beat/cycle; latency from acceptance to O_valid is 4 cycles with I_ready held high.
- S1:
  - Register the accumulator and read bias RAM at the group counter (synchronous read).
  - The group counter increments per accepted beat and wraps to 0 after I_groups-1.
  - The beat counter wraps to 0 after I_total-1; that beat is tagged last.
- S2: sum = sext(acc, ACC_W+2) + bias, where bias is sign-extended to ACC_W+2 then shifted per I_bias_shift. Shift magnitudes clamp to ACC_W.
- S3:
  - If relu is enabled and sum<0, sum=0.
  - If out_shift=k>0: add 2^(k-1), then arithmetic right shift k.
  - If out_shift<=0: left shift |k| in ACC_W+2+2^SHW width.
- S4:
  - Saturate to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - Each clipped lane adds 1 to O_sat_cnt; the counter saturates at all-ones.
  - Load the output register; O_last accompanies the tagged beat.
- Bias RAM: a write and a read to the same address in one cycle returns the old data. Writes during a frame are legal but not coherent.
- I_total=0 means no last tag is ever generated.
- Asserting reset mid-frame flushes the pipeline; no partial beat appears after reset release.

Optional Feature:
- Macro CNV_POST_LEAKY_EN.
- When defined:
  - Adds input I_leaky_shift (SHW bits).
  - With relu enabled, negative sums become sum>>>I_leaky_shift instead of 0.
  - I_leaky_shift=0 behaves as identity (no ReLU).
- When undefined: the port is absent and plain ReLU applies.

Test Plan:
- Lanes 0-3: acc=100, bias=3, bias_shift=2, out_shift=3, relu off, I_ready=1 -> (100+12+4)>>3=14 on all lanes, O_valid 4 cycles after acceptance.
- acc=-5000, relu on -> 0.
- acc=-5000, relu off, out_shift=3 -> -128, O_sat_cnt increments by LANES.
- acc=+5, out_shift=1 -> 3 (round half up).
- acc=-5, out_shift=1 -> -2.
- acc=1, out_shift=-4 -> 16.
- Groups=3 with biases {1,2,3}, 7 beats of acc=0, out_shift=0 -> outputs 1,2,3,1,2,3,1.
- Total=7 -> O_last only on beat 7; O_busy drops after it is accepted.
- Random I_ready toggling at 50% with 64 continuous beats -> no drops or duplicates; data stable while O_valid&&!I_ready; O_acc_ready low exactly during stall.
- I_cfg_load pulse mid-frame -> config unchanged.
- Reset asserted 2 cycles after acceptance -> O_valid=0 immediately and no output after release.
